// File: rtl/music_pkg.sv
// music_pkg: pitch codes, half-period helper, sequencer states and song ROM for music_player
package music_pkg;

    localparam logic [4:0] REST = 5'd0;
    localparam logic [4:0] C4 = 5'd1,  D4 = 5'd2,  E4 = 5'd3,  F4 = 5'd4,  G4 = 5'd5,  A4 = 5'd6,  B4 = 5'd7;
    localparam logic [4:0] C5 = 5'd8,  D5 = 5'd9,  E5 = 5'd10, F5 = 5'd11, G5 = 5'd12, A5 = 5'd13, B5 = 5'd14;
    localparam logic [4:0] C6 = 5'd15, D6 = 5'd16, E6 = 5'd17, F6 = 5'd18, G6 = 5'd19, A6 = 5'd20, B6 = 5'd21;

    localparam int NUM_PITCH = 22;

    // note frequencies in centi-hertz so the half period truncates exactly like CLK_HZ/(2*f)
    localparam int unsigned FREQ_CHZ [NUM_PITCH] = '{
        0,
        26163, 29366, 32963, 34923, 39200, 44000, 49388,
        52325, 58733, 65926, 69846, 78399, 88000, 98777,
        104650, 117466, 131851, 139691, 156798, 176000, 197553
    };

    typedef enum logic [2:0] {IDLE, PLAY, GAP, PAUSE, DONE} state_t;

    function automatic longint unsigned half_period(longint unsigned clk_hz, int code);
        if (code < 1 || code >= NUM_PITCH) return 64'd0;
        return clk_hz * 64'd100 / (64'd2 * 64'(FREQ_CHZ[code]));
    endfunction

    // {pitch, dur}; dur 0 stands for 8 tempo units
    localparam logic [7:0] SONG_ROM [32] = '{
        {A4, 3'd1}, {REST, 3'd2}, {C4, 3'd0}, {A4, 3'd1},
        {C4, 3'd2}, {D4, 3'd2}, {E4, 3'd2}, {F4, 3'd2}, {G4, 3'd2}, {A4, 3'd2}, {B4, 3'd2},
        {C5, 3'd2}, {D5, 3'd2}, {E5, 3'd2}, {F5, 3'd2}, {G5, 3'd2}, {A5, 3'd2}, {B5, 3'd2},
        {C6, 3'd2}, {D6, 3'd2}, {E6, 3'd2}, {F6, 3'd2}, {G6, 3'd2}, {A6, 3'd2}, {B6, 3'd4},
        {G6, 3'd2}, {E6, 3'd2}, {C6, 3'd4}, {G5, 3'd2}, {E5, 3'd2}, {C5, 3'd4}, {C4, 3'd0}
    };

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave that toggles beep every half_period cycles while run is high
module tone_gen #(
    parameter int HP_W = 18
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clear,
    input  logic            run,
    input  logic [HP_W-1:0] half_period,
    output logic            beep
);

    logic [HP_W-1:0] cnt;
    logic            wrap;

    assign wrap = cnt == half_period - 1'b1;

    // half-period counter; clear restarts the waveform low at each note start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            beep <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            beep <= 1'b0;
        end else if (run) begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            beep <= wrap ? ~beep : beep;
        end
    end

endmodule

// File: rtl/music_player.sv
// music_player: plays the song ROM on the buzzer; define MUSIC_LOOP_EN to loop the song instead of stopping
module music_player
    import music_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TEMPO_TICKS = 12_500_000,
    parameter int GAP_TICKS   = 1_000_000,
    parameter int SONG_LEN    = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        restart,
    output logic                        beep,
    output logic                        busy,
    output logic [$clog2(SONG_LEN)-1:0] note_idx
);

    localparam int IDX_W = $clog2(SONG_LEN);
    localparam int HP_W  = $clog2(half_period(64'(CLK_HZ), 1) + 1);
    localparam int DUR_W = $clog2(64'd8 * 64'(TEMPO_TICKS) + 1);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
`ifdef MUSIC_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    state_t            state, nxt;
    logic              restart_q, rst_edge;
    logic [DUR_W-1:0]  dur_cnt, note_len;
    logic [GAP_W-1:0]  gap_cnt;
    logic              resume_gap;
    logic [7:0]        entry;
    logic [4:0]        pitch;
    logic [3:0]        units;
    logic [HP_W-1:0]   hp_tab [32];
    logic [IDX_W-1:0]  next_idx;
    logic              note_end, gap_end, last, note_start, tone_run, tone_beep;

    for (genvar g = 0; g < 32; g++) begin : g_hp
        assign hp_tab[g] = HP_W'(half_period(64'(CLK_HZ), g));
    end

    assign rst_edge = restart & ~restart_q;
    assign entry    = SONG_ROM[note_idx];
    assign pitch    = entry[7:3];
    assign units    = entry[2:0] == 3'd0 ? 4'd8 : {1'b0, entry[2:0]};
    assign note_len = DUR_W'(units) * DUR_W'(TEMPO_TICKS);
    assign last     = note_idx == IDX_W'(SONG_LEN - 1);
    assign note_end = state == PLAY && dur_cnt == note_len - 1'b1;
    assign gap_end  = state == GAP && gap_cnt == GAP_W'(GAP_TICKS - 1);
    assign next_idx = (last && !LOOP) ? note_idx : note_idx + 1'b1;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    // next state; a restart edge overrides every other event
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = en ? PLAY : IDLE;
            PLAY:    nxt = !en ? PAUSE : note_end ? GAP : PLAY;
            GAP:     nxt = !en ? PAUSE : !gap_end ? GAP : (last && !LOOP) ? DONE : PLAY;
            PAUSE:   nxt = !en ? PAUSE : resume_gap ? GAP : PLAY;
            DONE:    nxt = en ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
        if (rst_edge) nxt = en ? PLAY : IDLE;
    end

    // outputs and tone control; the tone only advances on cycles that stay in PLAY
    always_comb begin
        busy       = state == PLAY || state == GAP;
        beep       = state == PLAY && tone_beep;
        note_start = nxt == PLAY && (rst_edge || state == IDLE || state == GAP);
        tone_run   = state == PLAY && nxt == PLAY && pitch != REST;
    end

    // counters, note index and restart edge register; a pause stops everything in place
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            restart_q  <= 1'b0;
            note_idx   <= '0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
            resume_gap <= 1'b0;
        end else begin
            restart_q <= restart;
            if (rst_edge) begin
                note_idx <= '0;
                dur_cnt  <= '0;
                gap_cnt  <= '0;
            end else if (state == IDLE && en) begin
                dur_cnt <= '0;
                gap_cnt <= '0;
            end else if ((state == PLAY || state == GAP) && !en) begin
                resume_gap <= state == GAP;
            end else if (state == PLAY) begin
                dur_cnt <= note_end ? '0 : dur_cnt + 1'b1;
            end else if (state == GAP) begin
                gap_cnt  <= gap_end ? '0 : gap_cnt + 1'b1;
                note_idx <= gap_end ? next_idx : note_idx;
            end else if (state == DONE && !en) begin
                note_idx <= '0;
            end
        end
    end

    tone_gen #(.HP_W(HP_W)) u_tone (
        .clk         (clk),
        .rstn        (rstn),
        .clear       (note_start),
        .run         (tone_run),
        .half_period (hp_tab[pitch]),
        .beep        (tone_beep)
    );

endmodule

// File: tb/tb_music_player.sv
// tb_music_player: scoreboard bench; stimulus queues expected output changes, a monitor checks each change
module tb_music_player;

    localparam int GAP = 10;

    logic       clk = 1'b0, rstn = 1'b0, en = 1'b0, restart = 1'b0;
    logic       beep, busy;
    logic [1:0] note_idx;

    int cyc = 0, n_chk = 0, n_fail = 0, horizon = 1_000_000_000;
    bit mon_on = 1'b0;

    typedef struct {
        int         c;
        logic       b;
        logic       y;
        logic [1:0] i;
    } ev_t;

    ev_t        q[$];
    ev_t        e;
    logic       m_beep = 1'b0, m_busy = 1'b0;
    logic [1:0] m_idx = 2'd0;
    logic [3:0] prev = 4'd0;

    music_player #(
        .CLK_HZ      (8800),
        .TEMPO_TICKS (100),
        .GAP_TICKS   (GAP),
        .SONG_LEN    (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .restart  (restart),
        .beep     (beep),
        .busy     (busy),
        .note_idx (note_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c);
        if (c <= horizon) q.push_back('{c, m_beep, m_busy, m_idx});
    endtask

    // A4 half period is 10 cycles, C4 is 16 at 8.8 kHz; the end-of-note cycle never toggles
    task automatic play_note(input int s, input int hp, input int len, input bit tail);
        for (int k = 1; hp > 0 && hp * k < len; k++) begin
            m_beep = ~m_beep;
            push(s + hp * k);
        end
        if (m_beep) begin
            m_beep = 1'b0;
            push(s + len);
        end
        if (tail) begin
            if (m_idx == 2'd3) begin
`ifdef MUSIC_LOOP_EN
                m_idx = 2'd0;
`else
                m_busy = 1'b0;
`endif
            end else begin
                m_idx = m_idx + 2'd1;
            end
            push(s + len + GAP);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on && {beep, busy, note_idx} !== prev) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_change at cycle %0d: beep=%b busy=%b idx=%0d, expected no change",
                         cyc, beep, busy, note_idx);
            end else begin
                e = q.pop_front();
                chk("event_cycle", cyc, e.c);
                chk("event_beep", beep, e.b);
                chk("event_busy", busy, e.y);
                chk("event_idx", note_idx, e.i);
            end
        end
        prev = {beep, busy, note_idx};
    end

    initial begin
        int c0, g, c1, c2, r0, t1, s3, s, p;
        repeat (3) @(negedge clk);
        chk("reset_beep", beep, 0);
        chk("reset_busy", busy, 0);
        chk("reset_idx", note_idx, 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        mon_on = 1'b1;
        // whole song from IDLE
        c0 = cyc;
        m_busy = 1'b1;
        push(c0 + 1);
        play_note(c0 + 1, 10, 100, 1'b1);
        play_note(c0 + 111, 0, 200, 1'b1);
        play_note(c0 + 321, 16, 800, 1'b1);
        play_note(c0 + 1131, 10, 100, 1'b1);
        g = c0 + 1241;
`ifdef MUSIC_LOOP_EN
        m_busy = 1'b0;
`else
        m_idx = 2'd0;
`endif
        push(g + 3);
        en = 1'b1;
        wait_cyc(g + 2);
        en = 1'b0;
        wait_cyc(g + 6);
        @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_beep = 1'b0; m_busy = 1'b0; m_idx = 2'd0;
        repeat (3) @(negedge clk);
        // asynchronous reset in the middle of a note
        c1 = cyc;
        m_busy = 1'b1;
        push(c1 + 1);
        for (int k = 1; k <= 3; k++) begin
            m_beep = ~m_beep;
            push(c1 + 1 + 10 * k);
        end
        m_beep = 1'b0; m_busy = 1'b0; m_idx = 2'd0;
        push(c1 + 36);
        en = 1'b1;
        wait_cyc(c1 + 35);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_beep", beep, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_idx", note_idx, 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_beep", beep, 0);
        chk("held_busy", busy, 0);
        chk("held_idx", note_idx, 0);
        // pause 50 cycles into note 0, resume, then restart on the last gap end
        c2 = cyc;
        m_busy = 1'b1;
        push(c2 + 1);
        for (int k = 1; k <= 4; k++) begin
            m_beep = ~m_beep;
            push(c2 + 1 + 10 * k);
        end
        m_busy = 1'b0;
        push(c2 + 51);
        r0 = c2 + 1051;
        m_busy = 1'b1;
        push(r0);
        for (int j = 0; j <= 4; j++) begin
            m_beep = ~m_beep;
            push(r0 + 1 + 10 * j);
        end
        m_beep = 1'b0;
        push(r0 + 51);
        m_idx = 2'd1;
        push(r0 + 61);
        t1 = r0 + 61;
        play_note(t1, 0, 200, 1'b1);
        play_note(t1 + 210, 16, 800, 1'b1);
        s3 = t1 + 1020;
        play_note(s3, 10, 100, 1'b0);
        s = s3 + 110;
        m_idx = 2'd0;
        push(s);
        p = s + 600;
        horizon = p - 1;
        play_note(s, 10, 100, 1'b1);
        play_note(s + 110, 0, 200, 1'b1);
        play_note(s + 320, 16, 800, 1'b1);
        horizon = 1_000_000_000;
        m_beep = 1'b0; m_busy = 1'b0; m_idx = 2'd0;
        push(p);
        en = 1'b1;
        wait_cyc(c2 + 50);
        en = 1'b0;
        wait_cyc(c2 + 1050);
        en = 1'b1;
        wait_cyc(s3 + 109);
        restart = 1'b1;
        wait_cyc(s + 499);
        restart = 1'b0;
        wait_cyc(p - 1);
        @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b0;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
